// File: rtl/spi_master_32bit_if.sv
// rtl/spi_master_32bit_if.sv - handshake and SPI bus signals for the 32-bit SPI master
interface spi_master_32bit_if;
    logic        start;
    logic [31:0] tx_data;
    logic        busy;
    logic        done;
    logic [31:0] rx_data;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;

    // The SPI master drives the bus and the completion handshake
    modport master (
        input  start, tx_data, MISO,
        output busy, done, rx_data, SCLK, CS, MOSI
    );

    // The local controller plus the remote slave
    modport slave (
        output start, tx_data, MISO,
        input  busy, done, rx_data, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master_32bit.sv
// rtl/spi_master_32bit.sv - SPI mode-0 master, 32-bit full duplex, MSB first
module spi_master_32bit #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_32bit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD
    } state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);

    state_t      r_state;
    logic [31:0] r_tx_shift;
    logic [31:0] r_rx_shift;
    logic [31:0] r_rx_data;
    logic [5:0]  r_bit_cnt;
    logic [7:0]  r_div_cnt;
    logic [3:0]  r_cnt;
    logic        r_sclk;
    logic        r_cs;
    logic        r_mosi;
    logic        r_busy;
    logic        r_done;
    logic        w_div_tc;

    assign w_div_tc = (r_div_cnt == DIV_LAST);

    assign bus.SCLK    = r_sclk;
    assign bus.CS      = r_cs;
    assign bus.MOSI    = r_mosi;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;

    // Transfer sequencer: CS setup, 64 SCLK half-periods, CS hold, done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_cnt      <= '0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_tx_shift <= bus.tx_data;
                        r_mosi     <= bus.tx_data[31];
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_rx_shift <= '0;
                        r_bit_cnt  <= '0;
                        r_div_cnt  <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt     <= '0;
                        r_div_cnt <= '0;
                        r_state   <= S_XFER;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_XFER: begin
                    if (w_div_tc) begin
                        r_div_cnt <= '0;
                        r_sclk    <= ~r_sclk;
                        if (!r_sclk) begin
                            // Rising edge: sample MISO at the same clk edge SCLK goes high
                            r_rx_shift <= {r_rx_shift[30:0], bus.MISO};
                            r_bit_cnt  <= r_bit_cnt + 6'd1;
                        end else if (r_bit_cnt < 6'd32) begin
                            // Falling edge: present the next bit a full half-period before the rise
                            r_mosi     <= r_tx_shift[30];
                            r_tx_shift <= {r_tx_shift[30:0], 1'b0};
                        end else begin
                            r_mosi  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt     <= '0;
                        r_cs      <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx_shift;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_32bit.sv
// tb/tb_spi_master_32bit.sv - directed self-checking bench for spi_master_32bit
module tb_spi_master_32bit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic        r_loop;
    logic [31:0] slave_word;
    logic [5:0]  slv_idx;
    logic [31:0] cap;
    logic        slv_bit;

    spi_master_32bit_if bus0 ();
    spi_master_32bit_if bus1 ();

    spi_master_32bit #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    spi_master_32bit #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(3)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: next bit presented on every SCLK fall, restarts when CS rises
    initial slv_idx = '0;
    always @(negedge bus0.SCLK or posedge bus0.CS) begin
        if (bus0.CS) slv_idx = '0;
        else if (slv_idx < 6'd32) slv_idx = slv_idx + 6'd1;
    end

    initial cap = '0;
    always @(posedge bus0.SCLK) cap = {cap[30:0], bus0.MOSI};

    always_comb begin
        slv_bit = 1'b0;
        if (slv_idx < 6'd32) slv_bit = slave_word[5'd31 - slv_idx[4:0]];
    end

    assign bus0.MISO = r_loop ? bus0.MOSI : slv_bit;
    assign bus1.MISO = bus1.MOSI;

    // One transfer on dut0, returning measured busy length, SCLK rises and done pulses
    task automatic run0(input logic [31:0] tx, output int busy_n, output int rises,
                        output int dones, output bit ok);
        logic ps;
        @(negedge clk);
        bus0.tx_data = tx;
        bus0.start   = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        busy_n = 0; rises = 0; dones = 0; ok = 1'b0; ps = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (bus0.busy) busy_n++;
            if (bus0.SCLK && !ps) rises++;
            ps = bus0.SCLK;
            if (bus0.done) begin
                dones++;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (bus0.done) dones++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus0.CS !== 1'b1) begin n_fail++; $display("FAIL reset_cs got=%b exp=1", bus0.CS); end
        n_checks++; if (bus0.SCLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", bus0.SCLK); end
        n_checks++; if (bus0.MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", bus0.MOSI); end
        n_checks++; if ({bus0.busy, bus0.done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done got=%b exp=00", {bus0.busy, bus0.done}); end
        n_checks++; if (bus0.rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_rx got=%h exp=00000000", bus0.rx_data); end
        n_checks++; if ({bus1.CS, bus1.SCLK, bus1.busy} !== 3'b100) begin n_fail++; $display("FAIL reset_dut1 got=%b exp=100", {bus1.CS, bus1.SCLK, bus1.busy}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus0.CS, bus0.busy} !== 2'b10) begin n_fail++; $display("FAIL idle_after_reset got=%b exp=10", {bus0.CS, bus0.busy}); end
    endtask

    task automatic test_loopback();
        int b, r, d; bit ok;
        r_loop = 1'b1;
        run0(32'hA5A55A5A, b, r, d, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL loop_timeout got=%b exp=1", ok); end
        n_checks++; if (r != 32) begin n_fail++; $display("FAIL loop_rises got=%0d exp=32", r); end
        n_checks++; if (d != 1) begin n_fail++; $display("FAIL loop_done_len got=%0d exp=1", d); end
        n_checks++; if (b != 260) begin n_fail++; $display("FAIL loop_busy got=%0d exp=260", b); end
        n_checks++; if (bus0.rx_data !== 32'hA5A55A5A) begin n_fail++; $display("FAIL loop_rx got=%h exp=a5a55a5a", bus0.rx_data); end
    endtask

    task automatic test_slave();
        int b, r, d; bit ok;
        r_loop = 1'b0;
        slave_word = 32'hDEADBEEF;
        run0(32'h12345678, b, r, d, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL slave_timeout got=%b exp=1", ok); end
        n_checks++; if (bus0.rx_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL slave_rx got=%h exp=deadbeef", bus0.rx_data); end
        n_checks++; if (cap !== 32'h12345678) begin n_fail++; $display("FAIL slave_cap got=%h exp=12345678", cap); end
        r_loop = 1'b1;
    endtask

    task automatic test_timing();
        int csf, r1, lastf, csr, hi_len, lo_len, bad_hi, bad_lo, mosi_bad, rises, busy_n;
        logic ps, pm, pc, done_at_csr;
        csf = -1; r1 = -1; lastf = -1; csr = -1; hi_len = 0; lo_len = 0;
        bad_hi = 0; bad_lo = 0; mosi_bad = 0; rises = 0; busy_n = 0; done_at_csr = 1'b0;
        @(negedge clk);
        bus1.tx_data = 32'h3C0FF0C3;
        bus1.start   = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        ps = 1'b0; pc = 1'b1; pm = bus1.MOSI;
        for (int c = 0; c < 400; c++) begin
            if (bus1.busy) busy_n++;
            if (pc && !bus1.CS) csf = c;
            if (bus1.SCLK && !ps) begin
                rises++;
                if (r1 < 0) r1 = c;
                else if (lo_len != 2) bad_lo++;
                hi_len = 1;
            end else if (!bus1.SCLK && ps) begin
                lastf = c;
                if (hi_len != 2) bad_hi++;
                lo_len = 1;
            end else begin
                hi_len++;
                lo_len++;
            end
            if (bus1.SCLK && (bus1.MOSI !== pm)) mosi_bad++;
            if (!pc && bus1.CS) begin
                csr = c;
                done_at_csr = bus1.done;
                break;
            end
            ps = bus1.SCLK; pm = bus1.MOSI; pc = bus1.CS;
            @(negedge clk);
        end
        n_checks++; if (csr < 0) begin n_fail++; $display("FAIL tim_timeout got=%0d exp=>=0", csr); end
        n_checks++; if (r1 - csf != 3) begin n_fail++; $display("FAIL tim_first_rise got=%0d exp=3", r1 - csf); end
        n_checks++; if (csr - lastf != 3) begin n_fail++; $display("FAIL tim_cs_hold got=%0d exp=3", csr - lastf); end
        n_checks++; if ((bad_hi != 0) || (bad_lo != 0)) begin n_fail++; $display("FAIL tim_half_period got=%0d/%0d exp=0/0", bad_hi, bad_lo); end
        n_checks++; if (mosi_bad != 0) begin n_fail++; $display("FAIL tim_mosi_stable got=%0d exp=0", mosi_bad); end
        n_checks++; if (rises != 32) begin n_fail++; $display("FAIL tim_rises got=%0d exp=32", rises); end
        n_checks++; if (busy_n != 132) begin n_fail++; $display("FAIL tim_busy got=%0d exp=132", busy_n); end
        n_checks++; if (done_at_csr !== 1'b1) begin n_fail++; $display("FAIL tim_done got=%b exp=1", done_at_csr); end
        n_checks++; if (bus1.rx_data !== 32'h3C0FF0C3) begin n_fail++; $display("FAIL tim_rx got=%h exp=3c0ff0c3", bus1.rx_data); end
    endtask

    task automatic test_ignore_start();
        int rises, inj, dones, extra;
        logic ps;
        bit ok;
        rises = 0; inj = 0; dones = 0; extra = 0; ok = 1'b0; ps = 1'b0;
        r_loop = 1'b1;
        @(negedge clk);
        bus0.tx_data = 32'h0F0F1234;
        bus0.start   = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (bus0.SCLK && !ps) rises++;
            ps = bus0.SCLK;
            if (rises == 10 && inj < 3) begin
                bus0.start   = 1'b1;
                bus0.tx_data = 32'hFFFFFFFF;
                inj++;
            end else begin
                bus0.start = 1'b0;
            end
            if (bus0.done) begin
                ok = 1'b1;
                dones++;
                break;
            end
            @(negedge clk);
        end
        bus0.start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus0.busy || !bus0.CS || bus0.done) extra++;
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL ign_timeout got=%b exp=1", ok); end
        n_checks++; if (inj != 3) begin n_fail++; $display("FAIL ign_injected got=%0d exp=3", inj); end
        n_checks++; if (bus0.rx_data !== 32'h0F0F1234) begin n_fail++; $display("FAIL ign_rx got=%h exp=0f0f1234", bus0.rx_data); end
        n_checks++; if (rises != 32) begin n_fail++; $display("FAIL ign_rises got=%0d exp=32", rises); end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL ign_no_second got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int rises, dones, b, r, d;
        logic ps;
        bit ok;
        rises = 0; dones = 0; ps = 1'b0;
        r_loop = 1'b1;
        @(negedge clk);
        bus0.tx_data = 32'h55AA55AA;
        bus0.start   = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (bus0.SCLK && !ps) rises++;
            ps = bus0.SCLK;
            if (rises == 16) break;
            @(negedge clk);
        end
        n_checks++; if (rises != 16) begin n_fail++; $display("FAIL rst_mid_reach got=%0d exp=16", rises); end
        reset = 1'b1;
        #1;
        n_checks++; if ({bus0.CS, bus0.SCLK, bus0.MOSI, bus0.busy} !== 4'b1000) begin n_fail++; $display("FAIL rst_mid_outs got=%b exp=1000", {bus0.CS, bus0.SCLK, bus0.MOSI, bus0.busy}); end
        n_checks++; if (bus0.rx_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rx got=%h exp=00000000", bus0.rx_data); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus0.done) dones++;
            @(negedge clk);
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
        run0(32'h13579BDF, b, r, d, ok);
        n_checks++; if ((ok !== 1'b1) || (bus0.rx_data !== 32'h13579BDF)) begin n_fail++; $display("FAIL rst_mid_next got=%h exp=13579bdf", bus0.rx_data); end
    endtask

    task automatic test_back_to_back();
        int dones, cs_high;
        logic [31:0] rx1, rx2;
        bit gap_done;
        dones = 0; cs_high = 0; gap_done = 1'b0; rx1 = '0; rx2 = '0;
        r_loop = 1'b1;
        @(negedge clk);
        bus0.tx_data = 32'h00000001;
        bus0.start   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (dones == 1 && !gap_done) begin
                if (bus0.CS) cs_high++;
                else gap_done = 1'b1;
            end
            if (bus0.done) begin
                dones++;
                if (dones == 1) begin
                    rx1 = bus0.rx_data;
                    bus0.tx_data = 32'h80000000;
                    cs_high = 1;
                end else begin
                    rx2 = bus0.rx_data;
                    bus0.start = 1'b0;
                    break;
                end
            end
        end
        bus0.start = 1'b0;
        n_checks++; if (dones != 2) begin n_fail++; $display("FAIL b2b_dones got=%0d exp=2", dones); end
        n_checks++; if (rx1 !== 32'h00000001) begin n_fail++; $display("FAIL b2b_rx1 got=%h exp=00000001", rx1); end
        n_checks++; if (rx2 !== 32'h80000000) begin n_fail++; $display("FAIL b2b_rx2 got=%h exp=80000000", rx2); end
        n_checks++; if (cs_high < 1) begin n_fail++; $display("FAIL b2b_cs_gap got=%0d exp=>=1", cs_high); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        r_loop   = 1'b1;
        slave_word   = '0;
        bus0.start   = 1'b0;
        bus0.tx_data = '0;
        bus1.start   = 1'b0;
        bus1.tx_data = '0;
        test_reset();
        test_loopback();
        test_slave();
        test_timing();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
